indication_pipe_packer: RTL and testbench

- Sits directly downstream of the SelectOutTest indication port. It accepts heard(rindex, v) method calls and buffers them in a small FIFO.
- Each call is packed into the 144-bit portal pipe word: a 16-bit method-id header plus a 128-bit payload. The word is presented to the pipe enq interface toward the host.
- The FIFO decouples the funnel response rule from host back-pressure. The block also keeps a sent-message count and a sticky protocol-error flag.

---
 rtl/indication_pipe_packer.sv | 62 ++++++
 tb/tb_indication_pipe_packer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/indication_pipe_packer.sv
// indication_pipe_packer: buffers heard(rindex, v) calls in a FIFO and packs them into 144-bit pipe words
module indication_pipe_packer #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] METHOD_ID = 16'd0,
  parameter int          CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             heard__ENA,
  input  logic [7:0]       heard_rindex,
  input  logic [31:0]      heard_v,
  output logic             heard__RDY,
  output logic             enq__ENA,
  output logic [143:0]     enq_v,
  input  logic             enq__RDY,
  output logic [CNT_W-1:0] msg_count,
  output logic             proto_err
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [39:0]      mem_q [DEPTH];
  logic             full, empty, wr_en, rd_en;
  logic [39:0]      head;
  assign full       = occ_q == (AW+1)'(DEPTH);
  assign empty      = occ_q == '0;
  assign heard__RDY = !full;
  assign wr_en      = heard__ENA && !full;
  assign enq__ENA   = !empty && enq__RDY;
  assign rd_en      = enq__ENA;
  assign head       = mem_q[rd_ptr_q];
  assign enq_v      = empty ? '0 : {METHOD_ID, 88'h0, head};
  assign msg_count  = cnt_q;
  assign proto_err  = err_q;
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    cnt_d    = rd_en ? cnt_q + CNT_W'(1) : cnt_q;
    err_d    = err_q | (heard__ENA & full);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {heard_rindex, heard_v};
  end
endmodule

// File: tb/tb_indication_pipe_packer.sv
// tb_indication_pipe_packer: directed, streaming, randomized and async-reset checks against a queue model
module tb_indication_pipe_packer;
  localparam int          DEPTH = 2;
  localparam logic [15:0] MID   = 16'hA5C3;
  localparam int          CNT_W = 32;
  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             heard__ENA = 1'b0;
  logic [7:0]       heard_rindex = '0;
  logic [31:0]      heard_v = '0;
  logic             heard__RDY;
  logic             enq__ENA;
  logic [143:0]     enq_v;
  logic             enq__RDY = 1'b0;
  logic [CNT_W-1:0] msg_count;
  logic             proto_err;

  indication_pipe_packer #(.DEPTH(DEPTH), .METHOD_ID(MID), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .heard__ENA(heard__ENA), .heard_rindex(heard_rindex),
    .heard_v(heard_v), .heard__RDY(heard__RDY), .enq__ENA(enq__ENA), .enq_v(enq_v),
    .enq__RDY(enq__RDY), .msg_count(msg_count), .proto_err(proto_err));

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  logic [39:0]      mq[$];
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  typedef struct {
    logic he; logic [7:0] r; logic [31:0] v; logic er;
    logic xrdy, xena, xerr, xne; logic [39:0] xd; logic [31:0] xcnt;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(string nm, logic [143:0] act, logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    logic [143:0] w;
    w = mq.size() != 0 ? {MID, 88'h0, mq[0]} : 144'h0;
    chk({tag, " rdy/ena/err"}, 144'({heard__RDY, enq__ENA, proto_err}),
        144'({mq.size() < DEPTH, mq.size() != 0 && enq__RDY, m_err}));
    chk({tag, " enq_v"}, enq_v, w);
    chk({tag, " msg_count"}, 144'(msg_count), 144'(m_cnt));
  endtask

  task automatic cycle(string tag);
    logic full, pop;
    #1 chk_model(tag);
    @(posedge CLK);
    full = mq.size() == DEPTH;
    pop  = mq.size() != 0 && enq__RDY;
    if (heard__ENA && full) m_err = 1'b1;
    if (pop) begin
      void'(mq.pop_front());
      m_cnt++;
    end
    if (heard__ENA && !full) mq.push_back({heard_rindex, heard_v});
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0; heard__ENA = 1'b1; enq__RDY = 1'b1;
    heard_rindex = 8'h55; heard_v = 32'h12345678;
    repeat (2) @(negedge CLK);
    #1 chk("reset state", 144'({heard__RDY, enq__ENA, proto_err, msg_count}),
           144'({1'b1, 1'b0, 1'b0, 32'h0}));
    @(negedge CLK);
    nRST = 1'b1; heard__ENA = 1'b0;
    mq.delete(); m_err = 1'b0; m_cnt = '0;
    cycle("post-reset empty");
  endtask

  initial begin
    int writes, cyc;
    tbl[0] = '{1'b1, 8'h03, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0, 32'd0};
    tbl[1] = '{1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 40'h03DEADBEEF, 32'd0};
    tbl[2] = '{1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0, 32'd1};
    tbl[3] = '{1'b1, 8'h00, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0, 32'd1};
    tbl[4] = '{1'b1, 8'h00, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 40'h1, 32'd1};
    tbl[5] = '{1'b1, 8'h00, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'h1, 32'd1};
    tbl[6] = '{1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 40'h1, 32'd1};
    tbl[7] = '{1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 40'h2, 32'd2};
    tbl[8] = '{1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 40'h0, 32'd3};
    @(negedge CLK);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      heard__ENA = tbl[i].he; heard_rindex = tbl[i].r; heard_v = tbl[i].v; enq__RDY = tbl[i].er;
      #1;
      chk($sformatf("tbl%0d rdy/ena/err", i), 144'({heard__RDY, enq__ENA, proto_err}),
          144'({tbl[i].xrdy, tbl[i].xena, tbl[i].xerr}));
      chk($sformatf("tbl%0d enq_v", i), enq_v, tbl[i].xne ? {MID, 88'h0, tbl[i].xd} : 144'h0);
      chk($sformatf("tbl%0d msg_count", i), 144'(msg_count), 144'(tbl[i].xcnt));
      @(posedge CLK); @(negedge CLK);
    end
    do_reset();
    enq__RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      heard__ENA = 1'b1; heard_rindex = 8'(i % 4); heard_v = 32'(i);
      cycle($sformatf("stream%0d", i));
    end
    heard__ENA = 1'b0;
    cycle("stream drain");
    chk("stream msg_count", 144'(msg_count), 144'd10);
    do_reset();
    writes = 0; cyc = 0;
    while (writes < 1000 && cyc < 20000) begin
      heard__ENA = (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      heard_rindex = 8'($urandom); heard_v = $urandom;
      enq__RDY = 1'($urandom_range(0, 1));
      if (heard__ENA) writes++;
      cycle("rand");
      cyc++;
    end
    chk("rand writes done", 144'(writes), 144'd1000);
    heard__ENA = 1'b0; enq__RDY = 1'b1;
    repeat (DEPTH + 1) cycle("rand drain");
    chk("rand msg_count", 144'(msg_count), 144'd1000);
    chk("rand proto_err", 144'(proto_err), 144'd0);
    enq__RDY = 1'b0; heard__ENA = 1'b1;
    heard_rindex = 8'hAA; heard_v = 32'hCAFEF00D; cycle("ar fill0");
    heard_rindex = 8'hBB; heard_v = 32'h0BADF00D; cycle("ar fill1");
    heard__ENA = 1'b0; enq__RDY = 1'b1;
    #2 nRST = 1'b0;
    #1 chk("async reset ena/cnt", 144'({enq__ENA, msg_count, heard__RDY}), 144'({1'b0, 32'h0, 1'b1}));
    chk("async reset enq_v", enq_v, 144'h0);
    @(negedge CLK);
    nRST = 1'b1;
    mq.delete(); m_err = 1'b0; m_cnt = '0;
    repeat (3) cycle("after async reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
